// File: rtl/reg_read_write_stage_p_if.sv
// rtl/reg_read_write_stage_p_if.sv - decode/execute side bundle for the register read / write-back stage
interface reg_read_write_stage_p_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              reg2Loc;
    logic              valueToStore;
    logic [ADDR_W-1:0] readAddr1;
    logic [ADDR_W-1:0] readAddr2;
    logic [ADDR_W-1:0] branchReadAddr;
    logic [DATA_W-1:0] address;
    logic              dest_valid;
    logic [ADDR_W-1:0] destAddr;
    logic              regWrite;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] WriteData;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [ADDR_W-1:0] addr2;

    modport master (
        output in_valid, reg2Loc, valueToStore, readAddr1, readAddr2, branchReadAddr,
        output address, dest_valid, destAddr, regWrite, writeAddr, WriteData, out_ready,
        input  in_ready, out_valid, ReadData1, ReadData2, addr2
    );

    modport slave (
        input  in_valid, reg2Loc, valueToStore, readAddr1, readAddr2, branchReadAddr,
        input  address, dest_valid, destAddr, regWrite, writeAddr, WriteData, out_ready,
        output in_ready, out_valid, ReadData1, ReadData2, addr2
    );
endinterface

// File: rtl/reg_read_write_stage_p.sv
// rtl/reg_read_write_stage_p.sv - register file read/write-back stage with bypass, busy scoreboard and output buffer
module reg_read_write_stage_p #(
    parameter int DATA_W   = 64,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    reg_read_write_stage_p_if.slave   bus
);
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;

    logic [ADDR_W-1:0] sel2;
    logic [DATA_W-1:0] rd1_val;
    logic [DATA_W-1:0] rd2_val;
    logic [DATA_W-1:0] op2_val;
    logic              wb_en;
    logic              busy1;
    logic              busy2;
    logic              hazard;
    logic              in_ready_c;
    logic              accept;

    // Zero register first, then same-cycle write-back bypass, then stored value.
    function automatic logic [DATA_W-1:0] bypass_read(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (a == ZR)
            return '0;
        else if (we && wa == a)
            return wd;
        else
            return stored;
    endfunction

    always_comb begin
        sel2    = bus.reg2Loc ? bus.readAddr2 : bus.branchReadAddr;
        wb_en   = bus.regWrite && (bus.writeAddr != ZR);
        rd1_val = bypass_read(bus.readAddr1, regs[bus.readAddr1], bus.regWrite,
                              bus.writeAddr, bus.WriteData);
        rd2_val = bypass_read(sel2, regs[sel2], bus.regWrite, bus.writeAddr, bus.WriteData);
        op2_val = bus.valueToStore ? bus.address : rd2_val;
    end

    // A busy source being written back this cycle is already satisfied by the bypass.
    always_comb begin
        busy1      = busy[bus.readAddr1] && !(bus.regWrite && bus.writeAddr == bus.readAddr1);
        busy2      = busy[sel2] && !(bus.regWrite && bus.writeAddr == sel2);
        hazard     = bus.in_valid && (busy1 || (!bus.valueToStore && busy2));
        in_ready_c = !hazard && (!bus.out_valid || bus.out_ready);
        accept     = bus.in_valid && in_ready_c;
    end

    assign bus.in_ready = in_ready_c;

    // Set after clear: a newly accepted producer outranks a completing one.
    always_comb begin
        busy_next = busy;
        if (wb_en)
            busy_next[bus.writeAddr] = 1'b0;
        if (accept && bus.dest_valid && bus.destAddr != ZR)
            busy_next[bus.destAddr] = 1'b1;
        busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_en) begin
            regs[bus.writeAddr] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.ReadData1 <= '0;
            bus.ReadData2 <= '0;
            bus.addr2     <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.ReadData1 <= rd1_val;
            bus.ReadData2 <= op2_val;
            bus.addr2     <= sel2;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_read_write_stage_p.sv
// tb/tb_reg_read_write_stage_p.sv - scoreboard bench for reg_read_write_stage_p
module tb_reg_read_write_stage_p;
    localparam int         NR = 32;
    localparam logic [4:0] ZR = 5'd31;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_read_write_stage_p_if #(.DATA_W(64), .ADDR_W(5)) ifc ();

    reg_read_write_stage_p #(.DATA_W(64), .NREGS(NR), .ADDR_W(5), .ZERO_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int nchecks = 0;
    int nerr    = 0;

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
        logic [4:0]  a2;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] m_regs [NR];
    logic        m_busy [NR];
    logic        m_ov;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [4:0] a);
        if (a == ZR) return 64'd0;
        if (ifc.regWrite && ifc.writeAddr == a) return ifc.WriteData;
        return m_regs[a];
    endfunction

    function automatic bit m_stalls_on(input logic [4:0] a);
        return m_busy[a] && !(ifc.regWrite && ifc.writeAddr == a);
    endfunction

    // Reference model: evaluated mid-cycle when every input is stable.
    always @(negedge clk) begin : model
        logic [4:0] s2;
        bit hz, exp_ir, acc;
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i] = 64'd0;
                m_busy[i] = 1'b0;
            end
            m_ov = 1'b0;
            sb.delete();
        end else begin
            s2     = ifc.reg2Loc ? ifc.readAddr2 : ifc.branchReadAddr;
            hz     = ifc.in_valid && (m_stalls_on(ifc.readAddr1) ||
                                      (!ifc.valueToStore && m_stalls_on(s2)));
            exp_ir = !hz && (!m_ov || ifc.out_ready);
            chk("in_ready", {63'd0, ifc.in_ready}, {63'd0, exp_ir});
            chk("out_valid", {63'd0, ifc.out_valid}, {63'd0, m_ov});
            acc = ifc.in_valid && exp_ir;
            if (acc)
                sb.push_back('{m_read(ifc.readAddr1),
                               ifc.valueToStore ? ifc.address : m_read(s2), s2});
            if (ifc.regWrite && ifc.writeAddr != ZR) begin
                m_regs[ifc.writeAddr] = ifc.WriteData;
                m_busy[ifc.writeAddr] = 1'b0;
            end
            if (acc && ifc.dest_valid && ifc.destAddr != ZR)
                m_busy[ifc.destAddr] = 1'b1;
            if (acc) m_ov = 1'b1;
            else if (ifc.out_ready) m_ov = 1'b0;
        end
    end

    // Monitor: compares consumed outputs against the scoreboard, and checks stalled outputs hold.
    always @(negedge clk) begin : monitor
        static logic        held = 1'b0;
        static logic [63:0] p1 = 64'd0;
        static logic [63:0] p2 = 64'd0;
        static logic [4:0]  pa = 5'd0;
        exp_t e;
        if (reset || !ifc.out_valid) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_rd1", ifc.ReadData1, p1);
                chk("hold_rd2", ifc.ReadData2, p2);
                chk("hold_addr2", {59'd0, ifc.addr2}, {59'd0, pa});
            end
            if (ifc.out_ready) begin
                if (sb.size() == 0) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL sb_underflow: output presented with no expected entry at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("sb_rd1", ifc.ReadData1, e.d1);
                    chk("sb_rd2", ifc.ReadData2, e.d2);
                    chk("sb_addr2", {59'd0, ifc.addr2}, {59'd0, e.a2});
                end
                held = 1'b0;
            end else begin
                held = 1'b1;
                p1 = ifc.ReadData1;
                p2 = ifc.ReadData2;
                pa = ifc.addr2;
            end
        end
    end

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ifc.in_valid = 0; ifc.reg2Loc = 0; ifc.valueToStore = 0;
        ifc.readAddr1 = 0; ifc.readAddr2 = 0; ifc.branchReadAddr = 0;
        ifc.address = 0; ifc.dest_valid = 0; ifc.destAddr = 0;
        ifc.regWrite = 0; ifc.writeAddr = 0; ifc.WriteData = 0;
        ifc.out_ready = 1;
    endtask

    task automatic ins(input logic [4:0] ra1, input logic r2l, input logic [4:0] ra2,
                       input logic [4:0] bra, input logic vts, input logic [63:0] adr,
                       input logic dv, input logic [4:0] da);
        ifc.in_valid = 1; ifc.readAddr1 = ra1; ifc.reg2Loc = r2l; ifc.readAddr2 = ra2;
        ifc.branchReadAddr = bra; ifc.valueToStore = vts; ifc.address = adr;
        ifc.dest_valid = dv; ifc.destAddr = da;
    endtask

    task automatic wb(input logic [4:0] wa, input logic [63:0] wd);
        ifc.regWrite = 1; ifc.writeAddr = wa; ifc.WriteData = wd;
        at_edge();
        ifc.regWrite = 0;
    endtask

    // Holds the presented instruction until accepted; returns the stall cycles seen.
    task automatic issue(output int n);
        n = 0;
        @(negedge clk);
        while (!ifc.in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n == 40) begin
            nchecks++;
            nerr++;
            $display("FAIL issue_timeout: instruction not accepted within 40 cycles at %0t", $time);
        end
        at_edge();
        ifc.in_valid = 0; ifc.dest_valid = 0; ifc.regWrite = 0;
    endtask

    function automatic logic [4:0] rnd_reg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? ZR : 5'(r);
    endfunction

    initial begin : stim
        int  n;
        bit  acc;
        logic [4:0] s2;
        clr();
        reset = 1;
        repeat (3) at_edge();
        chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
        chk("rst_rd1", ifc.ReadData1, 64'd0);
        chk("rst_rd2", ifc.ReadData2, 64'd0);
        chk("rst_addr2", {59'd0, ifc.addr2}, 64'd0);
        reset = 0;

        wb(5'd3, 64'hAA);
        ins(5'd3, 1, 5'd31, 5'd0, 0, 64'd0, 0, 5'd0);
        issue(n);
        chk("t1_out_valid", {63'd0, ifc.out_valid}, 64'd1);
        chk("t1_rd1", ifc.ReadData1, 64'hAA);
        chk("t1_rd2_zero", ifc.ReadData2, 64'd0);

        ifc.regWrite = 1; ifc.writeAddr = 5'd5; ifc.WriteData = 64'h1234;
        ins(5'd5, 1, 5'd0, 5'd0, 0, 64'd0, 0, 5'd0);
        issue(n);
        chk("t2_bypass", ifc.ReadData1, 64'h1234);
        ins(5'd5, 1, 5'd0, 5'd0, 0, 64'd0, 0, 5'd0);
        issue(n);
        chk("t2_stored", ifc.ReadData1, 64'h1234);

        ins(5'd0, 1, 5'd0, 5'd0, 0, 64'd0, 1, 5'd7);
        issue(n);
        ins(5'd7, 1, 5'd0, 5'd0, 0, 64'd0, 0, 5'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall", {63'd0, ifc.in_ready}, 64'd0);
        end
        at_edge();
        ifc.regWrite = 1; ifc.writeAddr = 5'd7; ifc.WriteData = 64'h55;
        issue(n);
        chk("t3_release_wait", n, 0);
        chk("t3_rd1", ifc.ReadData1, 64'h55);

        ins(5'd3, 1, 5'd0, 5'd0, 0, 64'd0, 0, 5'd0);
        issue(n);
        ifc.out_ready = 0;
        ins(5'd5, 1, 5'd0, 5'd0, 0, 64'd0, 0, 5'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_in_ready", {63'd0, ifc.in_ready}, 64'd0);
            chk("t4_rd1_held", ifc.ReadData1, 64'hAA);
        end
        at_edge();
        ifc.out_ready = 1;
        issue(n);
        chk("t4_release_wait", n, 0);
        chk("t4_rd1_new", ifc.ReadData1, 64'h1234);

        wb(5'd9, 64'h99);
        ins(5'd0, 1, 5'd0, 5'd0, 0, 64'd0, 1, 5'd9);
        issue(n);
        ins(5'd3, 0, 5'd0, 5'd9, 1, 64'hDEAD, 0, 5'd0);
        issue(n);
        chk("t5_no_stall", n, 0);
        chk("t5_rd2_addr", ifc.ReadData2, 64'hDEAD);
        chk("t5_addr2", {59'd0, ifc.addr2}, 64'd9);
        wb(5'd9, 64'h99);

        wb(5'd31, 64'hFF);
        ins(5'd31, 1, 5'd31, 5'd0, 0, 64'd0, 1, 5'd31);
        issue(n);
        chk("t6_no_stall", n, 0);
        chk("t6_rd1_zero", ifc.ReadData1, 64'd0);
        ins(5'd31, 1, 5'd31, 5'd0, 0, 64'd0, 0, 5'd0);
        issue(n);
        chk("t6_zero_never_busy", n, 0);

        ins(5'd0, 1, 5'd0, 5'd0, 0, 64'd0, 1, 5'd12);
        issue(n);
        ins(5'd12, 1, 5'd3, 5'd0, 0, 64'd0, 0, 5'd0);
        ifc.out_ready = 0;
        @(negedge clk);
        chk("t6_stalled", {63'd0, ifc.in_ready}, 64'd0);
        at_edge();
        reset = 1;
        at_edge();
        chk("t6_rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
        chk("t6_rst_rd1", ifc.ReadData1, 64'd0);
        reset = 0;
        ifc.out_ready = 1;
        issue(n);
        chk("t6_busy_cleared", n, 0);
        chk("t6_regs_cleared", ifc.ReadData2, 64'd0);

        clr();
        acc = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = ifc.in_valid && ifc.in_ready;
            at_edge();
            if (!ifc.in_valid || acc) begin
                ins(rnd_reg(), 1'($urandom), rnd_reg(), rnd_reg(), ($urandom % 4) == 0,
                    {$urandom, $urandom}, ($urandom % 2) == 0, rnd_reg());
                ifc.in_valid = ($urandom % 4) != 0;
                ifc.regWrite = ($urandom % 3) == 0;
                ifc.writeAddr = rnd_reg();
            end else begin
                s2 = ifc.reg2Loc ? ifc.readAddr2 : ifc.branchReadAddr;
                ifc.regWrite = ($urandom % 2) == 0;
                ifc.writeAddr = ($urandom % 2) ? ifc.readAddr1 : s2;
            end
            ifc.WriteData = {$urandom, $urandom};
            ifc.out_ready = ($urandom % 4) != 0;
        end

        clr();
        repeat (4) at_edge();
        chk("sb_drained", sb.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule

// File: doc/reg_read_write_stage_p.md
Name: reg_read_write_stage_p

Overview:
Parametrised register-read / write-back stage for the in-order pipeline. It contains the architectural register file, the reg2Loc and store-value operand muxes, a same-cycle write-to-read bypass and a busy-register scoreboard. Operands are registered into a one-deep output buffer with a valid/ready handshake. It sits between decode and execute and replaces the negedge-clocked regfile with a single posedge design that detects read-after-write hazards.

Parameters:
DATA_W, 64, register and operand width
NREGS, 32, number of architectural registers
ADDR_W, 5, register address width (2**ADDR_W >= NREGS)
ZERO_REG, 31, hard-wired zero register index

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts this cycle
reg2Loc  in  1  1: port 2 reads readAddr2; 0: port 2 reads branchReadAddr
valueToStore  in  1  1: ReadData2 takes address instead of the register value
readAddr1  in  ADDR_W  port 1 source register
readAddr2  in  ADDR_W  port 2 source (reg2Loc=1)
branchReadAddr  in  ADDR_W  port 2 source (reg2Loc=0)
address  in  DATA_W  alternate port-2 value
dest_valid  in  1  instruction will write destAddr
destAddr  in  ADDR_W  destination register to mark busy
regWrite  in  1  write-back enable
writeAddr  in  ADDR_W  write-back register
WriteData  in  DATA_W  write-back data
out_valid  out  1  output operands valid
out_ready  in  1  execute consumes operands
ReadData1  out  DATA_W  registered operand 1
ReadData2  out  DATA_W  registered operand 2
addr2  out  ADDR_W  registered port-2 register index actually selected

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: all NREGS registers, all busy bits, out_valid, ReadData1, ReadData2 and addr2 go to 0. Reset wins over every simultaneous event, including mid-handshake.
- Port-2 select: sel2 = reg2Loc ? readAddr2 : branchReadAddr.
- Combinational read of register a:
  - returns 0 if a == ZERO_REG;
  - otherwise returns WriteData if regWrite && writeAddr == a (bypass);
  - otherwise returns the regfile[a] contents.
- Operand 2 value = valueToStore ? address : read(sel2).
- Write-back: on posedge, if regWrite && writeAddr != ZERO_REG, then regfile[writeAddr] <= WriteData. Writes to ZERO_REG are dropped.
- Scoreboard (busy[NREGS]):
  - eff_busy(a) = busy[a] && !(regWrite && writeAddr == a). A same-cycle write-back satisfies the read via the bypass.
  - busy[ZERO_REG] is always 0.
  - hazard = in_valid && (eff_busy(readAddr1) || (!valueToStore && eff_busy(sel2))).
- Handshake:
  - in_ready = !hazard && (!out_valid || out_ready).
  - accept = in_valid && in_ready.
- On accept:
  - ReadData1 <= read(readAddr1); ReadData2 <= operand-2 value; addr2 <= sel2; out_valid <= 1.
  - If dest_valid && destAddr != ZERO_REG, set busy[destAddr].
- If out_valid && out_ready && !accept: out_valid <= 0; data outputs hold their last value.
- If out_valid && !out_ready: outputs hold stable (no change allowed).
- Busy clear: regWrite && writeAddr != ZERO_REG clears busy[writeAddr]. If the same cycle also sets the same register (accepted instruction with destAddr == writeAddr), the set wins, since the new producer is outstanding.
- Latency: an accepted instruction's operands appear on outputs the next cycle. Full throughput is 1 per cycle when out_ready is held high and there are no hazards.
- An instruction whose own destAddr equals one of its sources reads the old value. The hazard check uses pre-accept busy state.
- Write-back when nothing is busy is legal and updates the regfile only.
- in_ready may depend on in_valid and the addresses presented. Decode must not retract in_valid or change inputs while in_ready is 0.

Test Plan:
1. Reset, then write X3=0xAA via regWrite; next cycle accept readAddr1=3, reg2Loc=1, readAddr2=31 -> next cycle out_valid=1, ReadData1=0xAA, ReadData2=0.
2. Same-cycle bypass: regWrite writeAddr=5 WriteData=0x1234 while accepting readAddr1=5 -> ReadData1=0x1234 next cycle; regfile[5]=0x1234.
3. Hazard: accept an instruction with dest_valid, destAddr=7; next instruction reads readAddr1=7 -> in_ready=0 until a cycle with regWrite writeAddr=7 WriteData=0x55; the instruction is accepted that cycle and ReadData1=0x55.
4. Back-pressure: hold out_ready=0 with out_valid=1 for 3 cycles while in_valid=1 -> in_ready=0, outputs unchanged; raise out_ready -> new operands load next cycle.
5. Mux modes: reg2Loc=0, branchReadAddr=9 (X9=0x99), valueToStore=1, address=0xDEAD -> ReadData2=0xDEAD, addr2=9, no stall even if X9 is busy.
6. Zero register: write X31=0xFF, dest_valid destAddr=31 -> X31 reads 0 and never stalls; assert reset mid-stall -> out_valid=0 and all busy bits clear next cycle.
